// File: rtl/song_sequencer.sv
// Rhythm-game song sequencer: silent count-in, timed note slots, and hit/miss
// judgement of fret-button presses against the current note pattern.
module song_sequencer #(
  parameter int NOTE_TICKS  = 25_000_000,
  parameter int SONG_LEN    = 100,
  parameter int COUNT_BEATS = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       button_in,
  input  logic [4:0] songD,
  output logic [6:0] songDataPos,
  output logic       songplay_en,
  output logic       hit,
  output logic       miss,
  output logic [2:0] state,
  output logic       done
);

  localparam int TW = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
  localparam int BW = $clog2(COUNT_BEATS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(NOTE_TICKS - 1);
  localparam logic [BW-1:0] BEAT_LAST = BW'(COUNT_BEATS - 1);
  localparam logic [6:0]    POS_LAST  = 7'(SONG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COUNTIN = 3'd1,
    S_PLAY    = 3'd2,
    S_PAUSED  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_tick, w_tick_nxt;
  logic [BW-1:0] r_beat, w_beat_nxt;
  logic [6:0]    r_pos, w_pos_nxt;
  logic          r_judged, w_judged_nxt;
  logic          r_btn_prev;
  logic          r_hit, r_miss, r_play_en, r_done;

  logic w_press, w_wrap, w_hit_nxt, w_miss_nxt;

  assign w_press = button_in & ~r_btn_prev;
  assign w_wrap  = (r_tick == TICK_LAST);

  // Tick 0 is skipped because songD still reflects the previous slot then.
  assign w_hit_nxt  = (r_state == S_PLAY) && (r_tick != '0) && (songD != '0)
                      && !r_judged && w_press;
  // A slot only ends when the wrap actually advances (a pause on the wrap
  // cycle defers it until resume).
  assign w_miss_nxt = (r_state == S_PLAY) && !pause && w_wrap && (songD != '0)
                      && !r_judged && !w_hit_nxt;

  always_comb begin
    w_state_nxt  = r_state;
    w_tick_nxt   = r_tick;
    w_beat_nxt   = r_beat;
    w_pos_nxt    = r_pos;
    w_judged_nxt = r_judged | w_hit_nxt;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt  = S_COUNTIN;
          w_tick_nxt   = '0;
          w_beat_nxt   = '0;
          w_pos_nxt    = '0;
          w_judged_nxt = 1'b0;
        end
      end
      S_COUNTIN: begin
        if (w_wrap) begin
          w_tick_nxt = '0;
          if (r_beat == BEAT_LAST) begin
            w_state_nxt = S_PLAY;
            w_beat_nxt  = '0;
            w_pos_nxt   = '0;
          end else begin
            w_beat_nxt = r_beat + 1'b1;
          end
        end else begin
          w_tick_nxt = r_tick + 1'b1;
        end
      end
      S_PLAY: begin
        if (pause) begin
          w_state_nxt = S_PAUSED;
        end else if (w_wrap) begin
          w_tick_nxt   = '0;
          w_judged_nxt = 1'b0;
          if (r_pos == POS_LAST) w_state_nxt = S_DONE;
          else                   w_pos_nxt   = r_pos + 1'b1;
        end else begin
          w_tick_nxt = r_tick + 1'b1;
        end
      end
      S_PAUSED: begin
        if (pause) w_state_nxt = S_PLAY;
      end
      default: begin
        w_state_nxt  = S_IDLE;
        w_tick_nxt   = '0;
        w_beat_nxt   = '0;
        w_pos_nxt    = '0;
        w_judged_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_tick     <= '0;
      r_beat     <= '0;
      r_pos      <= '0;
      r_judged   <= 1'b0;
      r_btn_prev <= 1'b0;
      r_hit      <= 1'b0;
      r_miss     <= 1'b0;
      r_play_en  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick     <= w_tick_nxt;
      r_beat     <= w_beat_nxt;
      r_pos      <= w_pos_nxt;
      r_judged   <= w_judged_nxt;
      r_btn_prev <= button_in;
      r_hit      <= w_hit_nxt;
      r_miss     <= w_miss_nxt;
      r_play_en  <= (w_state_nxt == S_PLAY);
      r_done     <= (w_state_nxt == S_DONE);
    end
  end

  assign songDataPos = r_pos;
  assign songplay_en = r_play_en;
  assign hit         = r_hit;
  assign miss        = r_miss;
  assign state       = r_state;
  assign done        = r_done;

endmodule
